// File: rtl/sd_cmd_resp_rx.sv
// sd_cmd_resp_rx: SD CMD-line response receiver (start-bit hunt, MSB-first shift, CRC7/framing check)
// Ports:
//   clk, n_rst     - system clock, asynchronous active-low reset
//   sample_enable  - SD-clock sampling strobe; cmd_in is only looked at when high
//   cmd_in         - synchronized CMD line
//   rx_arm         - pulse: begin hunting for a response (ignored unless idle)
//   rx_abort       - pulse: drop reception, back to idle (wins over rx_arm)
//   busy           - receiver is waiting, shifting or checking
//   resp_data      - received frame, bit NUM_BITS-1 is the start bit
//   resp_valid     - one-clk pulse when frame and flags are valid
//   crc_err, end_err, dir_err - CRC7 mismatch, end bit 0, transmission bit 1
//   timeout        - one-clk pulse: no start bit within TIMEOUT_STROBES strobes
module sd_cmd_resp_rx #(
  parameter int NUM_BITS        = 48,
  parameter int CRC_EN          = 1,
  parameter int TIMEOUT_STROBES = 64
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                sample_enable,
  input  logic                cmd_in,
  input  logic                rx_arm,
  input  logic                rx_abort,
  output logic                busy,
  output logic [NUM_BITS-1:0] resp_data,
  output logic                resp_valid,
  output logic                crc_err,
  output logic                end_err,
  output logic                dir_err,
  output logic                timeout
);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_STROBES + 1);
  typedef enum logic [2:0] {IDLE, WAIT_START, SHIFT, CHECK, DONE} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [6:0] crc, crc_next;
  logic tmo_hit, last_bit;
  // CRC7 x^7+x^3+1, MSB first: feedback enters at bits 0 and 3
  assign crc_next = {crc[5:0], 1'b0} ^ ({7{crc[6] ^ cmd_in}} & 7'h09);
  // an idle-high strobe that completes the Ncr window; a low bit on that strobe takes priority
  assign tmo_hit  = state == WAIT_START && sample_enable && cmd_in && tcnt == TW'(TIMEOUT_STROBES - 1);
  assign last_bit = state == SHIFT && sample_enable && cnt == CW'(NUM_BITS - 1);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    if (rx_abort) state_next = IDLE;
    else
      case (state)
        IDLE:       state_next = rx_arm ? WAIT_START : IDLE;
        WAIT_START: state_next = (sample_enable && !cmd_in) ? SHIFT : tmo_hit ? IDLE : WAIT_START;
        SHIFT:      state_next = last_bit ? CHECK : SHIFT;
        CHECK:      state_next = DONE;
        default:    state_next = IDLE;
      endcase
  end
  always_comb begin
    busy       = state == WAIT_START || state == SHIFT || state == CHECK;
    resp_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      resp_data <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      crc       <= '0;
      crc_err   <= 1'b0;
      end_err   <= 1'b0;
      dir_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!rx_abort)
        case (state)
          IDLE:
            if (rx_arm) begin
              resp_data <= '0;
              cnt       <= '0;
              tcnt      <= '0;
              crc       <= '0;
              crc_err   <= 1'b0;
              end_err   <= 1'b0;
              dir_err   <= 1'b0;
            end
          WAIT_START:
            if (sample_enable && !cmd_in) begin
              resp_data <= {resp_data[NUM_BITS-2:0], cmd_in};
              cnt       <= CW'(1);
              crc       <= crc_next;
            end else if (sample_enable) begin
              tcnt    <= tcnt + TW'(1);
              timeout <= tmo_hit;
            end
          SHIFT:
            if (sample_enable) begin
              resp_data <= {resp_data[NUM_BITS-2:0], cmd_in};
              cnt       <= cnt + CW'(1);
              if (cnt < CW'(NUM_BITS - 8)) crc <= crc_next;
            end
          CHECK: begin
            end_err <= ~resp_data[0];
            dir_err <= resp_data[NUM_BITS-2];
            crc_err <= (CRC_EN != 0) && (crc != resp_data[7:1]);
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// tb_sd_cmd_resp_rx: directed checks of sd_cmd_resp_rx in R1 (CRC on/off) and R2 configurations
module tb_sd_cmd_resp_rx;
  logic clk = 1'b0, n_rst = 1'b0, sample_enable = 1'b0, cmd_in = 1'b1, rx_arm = 1'b0, rx_abort = 1'b0;
  logic busy, resp_valid, crc_err, end_err, dir_err, timeout;
  logic [47:0] resp_data;
  logic nc_busy, nc_valid, nc_crc, nc_end, nc_dir, nc_tmo;
  logic [47:0] nc_data;
  logic r2_busy, r2_valid, r2_crc, r2_end, r2_dir, r2_tmo;
  logic [135:0] r2_data;
  int n_cmp = 0, n_fail = 0, vcnt = 0;
  logic tmo_seen = 1'b0;

  always #5 clk = ~clk;

  sd_cmd_resp_rx #(.NUM_BITS(48), .CRC_EN(1), .TIMEOUT_STROBES(64)) dut (
    .clk(clk), .n_rst(n_rst), .sample_enable(sample_enable), .cmd_in(cmd_in), .rx_arm(rx_arm),
    .rx_abort(rx_abort), .busy(busy), .resp_data(resp_data), .resp_valid(resp_valid),
    .crc_err(crc_err), .end_err(end_err), .dir_err(dir_err), .timeout(timeout));
  sd_cmd_resp_rx #(.NUM_BITS(48), .CRC_EN(0), .TIMEOUT_STROBES(64)) dut_nc (
    .clk(clk), .n_rst(n_rst), .sample_enable(sample_enable), .cmd_in(cmd_in), .rx_arm(rx_arm),
    .rx_abort(rx_abort), .busy(nc_busy), .resp_data(nc_data), .resp_valid(nc_valid),
    .crc_err(nc_crc), .end_err(nc_end), .dir_err(nc_dir), .timeout(nc_tmo));
  sd_cmd_resp_rx #(.NUM_BITS(136), .CRC_EN(0), .TIMEOUT_STROBES(64)) dut_r2 (
    .clk(clk), .n_rst(n_rst), .sample_enable(sample_enable), .cmd_in(cmd_in), .rx_arm(rx_arm),
    .rx_abort(rx_abort), .busy(r2_busy), .resp_data(r2_data), .resp_valid(r2_valid),
    .crc_err(r2_crc), .end_err(r2_end), .dir_err(r2_dir), .timeout(r2_tmo));

  always @(negedge clk) begin
    if (resp_valid) vcnt++;
    if (timeout) tmo_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [47:0] f;
    logic ec, ee, ed;
  } vec_t;
  vec_t vt[5];

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    cmd_in = b;
    sample_enable = 1'b1;
    tick();
    sample_enable = 1'b0;
    cmd_in = 1'b1;
    repeat (gap - 1) tick();
  endtask

  task automatic arm();
    rx_arm = 1'b1;
    tick();
    rx_arm = 1'b0;
  endtask

  task automatic abort();
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
  endtask

  // arm, idle-high strobes, then the frame; last bit strobe returns in the CHECK cycle
  task automatic send48(input logic [47:0] f, input int idle, input int gap);
    arm();
    repeat (idle) strobe(1'b1, gap);
    for (int i = 47; i >= 1; i--) strobe(f[i], gap);
    strobe(f[0], 1);
  endtask

  task automatic done48(input string nm, input logic [47:0] f, input logic ec, input logic ee, input logic ed);
    chk({nm, "_chk_valid"}, resp_valid, 0);
    chk({nm, "_chk_busy"}, busy, 1);
    tick();
    chk({nm, "_valid"}, resp_valid, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_data"}, resp_data, f);
    chk({nm, "_flags"}, {crc_err, end_err, dir_err}, {ec, ee, ed});
    chk({nm, "_nc_data"}, nc_data, f);
    chk({nm, "_nc_flags"}, {nc_valid, nc_crc, nc_end, nc_dir}, {1'b1, 1'b0, ee, ed});
    tick();
    chk({nm, "_valid_end"}, resp_valid, 0);
    chk({nm, "_hold"}, {resp_data, crc_err, end_err, dir_err}, {f, ec, ee, ed});
  endtask

  initial begin
    logic [47:0] good;
    logic [135:0] r2;
    int v0;
    good = {8'h37, 32'h0000_0120, crc7(40'h37_0000_0120), 1'b1};
    vt[0] = '{good, 1'b0, 1'b0, 1'b0};
    vt[1] = '{good ^ 48'h8, 1'b1, 1'b0, 1'b0};
    vt[2] = '{good ^ 48'h1, 1'b0, 1'b1, 1'b0};
    vt[3] = '{48'h40_0000_0000_95, 1'b0, 1'b0, 1'b1};
    vt[4] = '{48'h48_0000_01AA_86, 1'b0, 1'b1, 1'b1};
    r2 = {8'h3F, 120'h0123_4567_89AB_CDEF_0011_2233_4455_66, 8'hA5};

    repeat (2) tick();
    chk("reset_data", resp_data, 0);
    chk("reset_outs", {busy, resp_valid, crc_err, end_err, dir_err, timeout}, 0);
    n_rst = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      send48(vt[k].f, 3, 4);
      done48($sformatf("vec%0d", k), vt[k].f, vt[k].ec, vt[k].ee, vt[k].ed);
    end

    v0 = vcnt;
    arm();
    repeat (63) strobe(1'b1, 2);
    chk("tmo_before", {timeout, busy}, 2'b01);
    strobe(1'b1, 1);
    chk("tmo_pulse", {timeout, busy}, 2'b10);
    tick();
    chk("tmo_pulse_end", timeout, 0);
    chk("tmo_no_valid", vcnt, v0);

    tmo_seen = 1'b0;
    send48(good, 63, 2);
    done48("start_on_64", good, 1'b0, 1'b0, 1'b0);
    chk("start_on_64_no_tmo", tmo_seen, 0);

    v0 = vcnt;
    arm();
    for (int i = 47; i >= 28; i--) strobe(good[i], 2);
    abort();
    chk("abort_busy", busy, 0);
    chk("abort_data", resp_data, {28'b0, good[47:28]});
    repeat (5) tick();
    chk("abort_no_valid", vcnt, v0);
    send48(good, 2, 3);
    done48("rearm", good, 1'b0, 1'b0, 1'b0);

    arm();
    for (int i = 47; i >= 38; i--) strobe(good[i], 2);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_data", resp_data, 0);
    chk("async_rst_outs", {busy, resp_valid, crc_err, end_err, dir_err, timeout}, 0);
    tick();
    n_rst = 1'b1;
    tick();

    rx_arm = 1'b1;
    rx_abort = 1'b1;
    tick();
    rx_arm = 1'b0;
    rx_abort = 1'b0;
    chk("arm_abort_busy", busy, 0);
    strobe(1'b0, 2);
    chk("arm_abort_stay_idle", busy, 0);

    abort();
    arm();
    for (int i = 135; i >= 1; i--) strobe(r2[i], 1);
    strobe(r2[0], 1);
    chk("r2_chk", {r2_valid, r2_busy}, 2'b01);
    tick();
    chk("r2_valid", {r2_valid, r2_busy}, 2'b10);
    chk("r2_data", r2_data, r2);
    chk("r2_flags", {r2_crc, r2_end, r2_dir, r2_tmo}, 0);
    tick();
    chk("r2_valid_end", r2_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_cmd_resp_rx.md
Name: sd_cmd_resp_rx

Overview:
Serial-to-parallel receiver for SD CMD-line responses. It is the receive counterpart of the command transmit shift path. When armed, it hunts for the start bit and shifts in a fixed-length MSB-first frame on SD-clock sample strobes. It then checks the transmission bit, CRC7 and end bit, and presents the whole frame in parallel with a one-cycle valid pulse to the SD command controller FSM.

Parameters:
NUM_BITS, 48, frame length in bits including start and end bits (48 for R1/R3/R6/R7, 136 for R2)
CRC_EN, 1, 1 = check CRC7 over frame bits [NUM_BITS-1:8] against bits [7:1]; 0 = crc_err forced 0
TIMEOUT_STROBES, 64, number of idle-high strobes in WAIT_START before timeout (Ncr limit)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
sample_enable  input  1  one-clk strobe marking an SD-clock sampling point; cmd_in is used only when this is 1
cmd_in  input  1  synchronized SD CMD line
rx_arm  input  1  one-clk pulse: start listening for a response
rx_abort  input  1  one-clk pulse: abandon reception and return to IDLE
busy  output  1  high in WAIT_START, SHIFT, CHECK
resp_data  output  NUM_BITS  received frame; bit NUM_BITS-1 = start bit
resp_valid  output  1  one-clk pulse: frame complete, data and flags valid
crc_err  output  1  CRC7 mismatch (CRC_EN=1 only)
end_err  output  1  end bit (bit 0) was 0
dir_err  output  1  transmission bit (bit NUM_BITS-2) was 1
timeout  output  1  one-clk pulse: no start bit within TIMEOUT_STROBES

Behaviour:
- Reset: state IDLE. resp_data, the bit counter, the timeout counter and the CRC register are all 0. busy, resp_valid, crc_err, end_err, dir_err and timeout are all 0.
- States: IDLE, WAIT_START, SHIFT, CHECK, DONE.
- IDLE: on rx_arm, go to WAIT_START. On that transition, clear resp_data, the error flags, the timeout counter, the bit counter and the CRC register.
- WAIT_START, on each strobe:
  - If cmd_in=0, shift this start bit in, set bit count to 1 and go to SHIFT.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_STROBES, pulse timeout for the following clk and go to IDLE.
  - If a start bit arrives on the same strobe that would reach the limit, the start bit wins and no timeout is raised.
- SHIFT, on each strobe:
  - Shift left: resp_data <= {resp_data[NUM_BITS-2:0], cmd_in}.
  - Increment the bit count.
  - Update CRC7 (polynomial x^7+x^3+1, init 0, MSB first) for the first NUM_BITS-8 bits; the start bit is included in this count.
  - When the count reaches NUM_BITS, go to CHECK.
- No strobe: all registers hold. Strobe spacing is arbitrary, from every clk to sparse.
- CHECK (exactly 1 clk):
  - end_err = ~resp_data[0].
  - dir_err = resp_data[NUM_BITS-2].
  - crc_err = CRC_EN & (crc != resp_data[7:1]).
  - Go to DONE.
- DONE (1 clk): resp_valid=1, then go to IDLE.
- Latency: if the final bit is sampled on the strobe in clk cycle E, state is CHECK in E+1 and resp_valid is high only in E+2.
- Hold: resp_data and the error flags hold their values until the next rx_arm clears them.
- rx_abort: from any state returns to IDLE on the next edge. No resp_valid or timeout is produced, and resp_data and flags are left unchanged. If rx_abort and rx_arm are asserted together, abort wins.
- rx_arm outside IDLE is ignored.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Test Plan:
- Good R1 frame, strobe every 4 clk, CRC_EN=1: arm, 3 idle-high strobes, then 48 bits of 0x_37_00000120_<bench CRC7>_1 with start=0 and trans=0 -> resp_data matches, resp_valid high exactly 2 clk after the last-bit strobe, crc_err=end_err=dir_err=0, busy falls with resp_valid.
- CRC corruption: same frame with bit 3 flipped -> resp_valid=1, crc_err=1, other flags 0. Repeat with CRC_EN=0 -> crc_err=0.
- Framing errors: end bit driven 0 -> end_err=1; trans bit driven 1 -> dir_err=1. Both errors in one frame -> both flags set.
- Timeout, TIMEOUT_STROBES=64: arm, hold cmd_in=1 for 64 strobes -> one-clk timeout pulse after the 64th strobe, busy=0, resp_valid never asserted. Start bit on the 64th strobe -> no timeout and the frame is received normally.
- Abort/reset: rx_abort after 20 bits shifted -> IDLE, no resp_valid; re-arm and receive a good frame correctly. Assert n_rst low mid-SHIFT -> all outputs 0 asynchronously. Assert rx_arm and rx_abort in the same cycle from IDLE -> stays IDLE.
- Back-to-back strobes with NUM_BITS=136: strobe every clk, 136-bit R2 frame with CRC_EN=0 -> full frame captured, resp_valid at E+2.
